// File: rtl/io_input_conditioner.sv
// ---------------------------------------------------------------------------
// io_input_conditioner
//
// Conditions the DE10 board push-buttons and slide switches before they reach
// the core's key/switch inputs. Every bit runs through its own independent
// channel: a 2-FF synchroniser, a stable-level register and a debounce counter.
// A new level is accepted only after it has been seen for DB_CYCLES
// consecutive cycles. Keys also produce registered one-cycle press/release
// strobes on accepted transitions.
//
// Optional build macro: IO_INPUT_COND_STICKY_EN
//   Adds i_evt_clr / o_key_evt: a per-key sticky flag that is set by a press
//   strobe and cleared by i_evt_clr (set wins when both occur together).
//
// Ports:
//   i_clk          core clock (25 MHz PLL domain)
//   i_reset        synchronous, active-high reset
//   i_key_raw      raw keys, asynchronous, active-low
//   i_sw_raw       raw switches, asynchronous
//   i_evt_clr      (macro only) per-key sticky event clear
//   o_key_evt      (macro only) per-key sticky press event
//   o_io_key       debounced key level, board polarity (1 = released)
//   o_io_sw        debounced switch level
//   o_key_press    1-cycle pulse on debounced 1->0
//   o_key_release  1-cycle pulse on debounced 0->1
// ---------------------------------------------------------------------------
module io_input_conditioner #(
  parameter int KEY_W     = 3,
  parameter int SW_W      = 10,
  parameter int DB_CYCLES = 250000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [KEY_W-1:0] i_key_raw,
  input  logic [SW_W-1:0]  i_sw_raw,
`ifdef IO_INPUT_COND_STICKY_EN
  input  logic [KEY_W-1:0] i_evt_clr,
  output logic [KEY_W-1:0] o_key_evt,
`endif
  output logic [KEY_W-1:0] o_io_key,
  output logic [SW_W-1:0]  o_io_sw,
  output logic [KEY_W-1:0] o_key_press,
  output logic [KEY_W-1:0] o_key_release
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  // Terminal count: the level is accepted on the edge where cnt already holds
  // DB_CYCLES-1, so the counter never reaches DB_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [KEY_W-1:0] key_s0_r;
  logic [KEY_W-1:0] key_s1_r;
  logic [KEY_W-1:0] key_st_r;
  logic [CNT_W-1:0] key_cnt_r [KEY_W];
  logic [KEY_W-1:0] key_accept_s;
  logic [KEY_W-1:0] key_press_r;
  logic [KEY_W-1:0] key_release_r;

  logic [SW_W-1:0]  sw_s0_r;
  logic [SW_W-1:0]  sw_s1_r;
  logic [SW_W-1:0]  sw_st_r;
  logic [CNT_W-1:0] sw_cnt_r [SW_W];
  logic [SW_W-1:0]  sw_accept_s;

  // Per-bit acceptance: synchronised level differs and the count is complete.
  always_comb begin
    key_accept_s = {KEY_W{1'b0}};
    sw_accept_s  = {SW_W{1'b0}};
    for (int i = 0; i < KEY_W; i++) begin
      if ((key_s1_r[i] != key_st_r[i]) && (key_cnt_r[i] == CNT_LAST)) begin
        key_accept_s[i] = 1'b1;
      end else begin
        key_accept_s[i] = 1'b0;
      end
    end
    for (int i = 0; i < SW_W; i++) begin
      if ((sw_s1_r[i] != sw_st_r[i]) && (sw_cnt_r[i] == CNT_LAST)) begin
        sw_accept_s[i] = 1'b1;
      end else begin
        sw_accept_s[i] = 1'b0;
      end
    end
  end

  // Key channels: synchroniser, debounce counter, stable level and strobes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      key_s0_r      <= {KEY_W{1'b1}};
      key_s1_r      <= {KEY_W{1'b1}};
      key_st_r      <= {KEY_W{1'b1}};
      key_press_r   <= {KEY_W{1'b0}};
      key_release_r <= {KEY_W{1'b0}};
      for (int i = 0; i < KEY_W; i++) begin
        key_cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      key_s0_r <= i_key_raw;
      key_s1_r <= key_s0_r;
      for (int i = 0; i < KEY_W; i++) begin
        // Any return to the stable level restarts the debounce window.
        if (key_s1_r[i] == key_st_r[i]) begin
          key_cnt_r[i] <= CNT_ZERO;
        end else if (key_accept_s[i]) begin
          key_st_r[i]  <= key_s1_r[i];
          key_cnt_r[i] <= CNT_ZERO;
        end else begin
          key_cnt_r[i] <= key_cnt_r[i] + CNT_ONE;
        end
        // Strobes fire on the same edge the stable level changes.
        key_press_r[i]   <= key_accept_s[i] & ~key_s1_r[i];
        key_release_r[i] <= key_accept_s[i] &  key_s1_r[i];
      end
    end
  end

  // Switch channels: synchroniser, debounce counter and stable level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_s0_r <= {SW_W{1'b0}};
      sw_s1_r <= {SW_W{1'b0}};
      sw_st_r <= {SW_W{1'b0}};
      for (int i = 0; i < SW_W; i++) begin
        sw_cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sw_s0_r <= i_sw_raw;
      sw_s1_r <= sw_s0_r;
      for (int i = 0; i < SW_W; i++) begin
        if (sw_s1_r[i] == sw_st_r[i]) begin
          sw_cnt_r[i] <= CNT_ZERO;
        end else if (sw_accept_s[i]) begin
          sw_st_r[i]  <= sw_s1_r[i];
          sw_cnt_r[i] <= CNT_ZERO;
        end else begin
          sw_cnt_r[i] <= sw_cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef IO_INPUT_COND_STICKY_EN
  logic [KEY_W-1:0] key_evt_r;

  // Sticky press flag; a press strobe in the clear cycle keeps it set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      key_evt_r <= {KEY_W{1'b0}};
    end else begin
      key_evt_r <= (key_evt_r & ~i_evt_clr) | key_press_r;
    end
  end

  assign o_key_evt = key_evt_r;
`endif

  assign o_io_key      = key_st_r;
  assign o_io_sw       = sw_st_r;
  assign o_key_press   = key_press_r;
  assign o_key_release = key_release_r;

endmodule

// File: tb/tb_io_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_io_input_conditioner
//
// Directed bench for io_input_conditioner with DB_CYCLES = 4. Stimulus pushes
// hand-computed expected outputs, stamped with the cycle they must appear in,
// into a queue; a monitor on the falling edge pops and compares them. In
// cycles without an expectation the monitor requires both strobes to be idle.
// Cycle n = value of cyc after rising edge n; an input driven while cyc == n
// is first sampled at edge n+1 and reaches the output at edge n+6.
// ---------------------------------------------------------------------------
module tb_io_input_conditioner;

  localparam int KEY_W = 3;
  localparam int SW_W  = 10;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [KEY_W-1:0] key_raw;
  logic [SW_W-1:0]  sw_raw;
  logic [KEY_W-1:0] io_key;
  logic [SW_W-1:0]  io_sw;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_release;
`ifdef IO_INPUT_COND_STICKY_EN
  logic [KEY_W-1:0] evt_clr;
  logic [KEY_W-1:0] key_evt;
`endif

  always #5 clk = ~clk;

  io_input_conditioner #(
    .KEY_W(KEY_W), .SW_W(SW_W), .DB_CYCLES(DB)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_key_raw    (key_raw),
    .i_sw_raw     (sw_raw),
`ifdef IO_INPUT_COND_STICKY_EN
    .i_evt_clr    (evt_clr),
    .o_key_evt    (key_evt),
`endif
    .o_io_key     (io_key),
    .o_io_sw      (io_sw),
    .o_key_press  (key_press),
    .o_key_release(key_release)
  );

  typedef struct {
    int               at;
    logic [KEY_W-1:0] key;
    logic [SW_W-1:0]  sw;
    logic [KEY_W-1:0] press;
    logic [KEY_W-1:0] rel;
    logic [KEY_W-1:0] evt;
    bit               chk_evt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   bad;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop the expectation due this cycle, else require idle strobes.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
          cur = exp_q.pop_front();
          checks++;
          bad = (cur.at != cyc) || (io_key !== cur.key) || (io_sw !== cur.sw) ||
                (key_press !== cur.press) || (key_release !== cur.rel);
`ifdef IO_INPUT_COND_STICKY_EN
          if (cur.chk_evt && (key_evt !== cur.evt)) bad = 1'b1;
          if (bad) $display("FAIL out_check cyc=%0d due=%0d evt=%b want=%b", cyc, cur.at, key_evt, cur.evt);
`endif
          if (bad) begin
            errors++;
            $display("FAIL out_check cyc=%0d due=%0d key=%b want=%b sw=%h want=%h press=%b want=%b rel=%b want=%b",
                     cyc, cur.at, io_key, cur.key, io_sw, cur.sw, key_press, cur.press, key_release, cur.rel);
          end
        end else begin
          checks++;
          if (key_press !== 3'b000 || key_release !== 3'b000) begin
            errors++;
            $display("FAIL idle_strobe cyc=%0d press=%b rel=%b want=000/000", cyc, key_press, key_release);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input int at, input logic [KEY_W-1:0] k, input logic [SW_W-1:0] s,
                      input logic [KEY_W-1:0] p, input logic [KEY_W-1:0] r,
                      input logic [KEY_W-1:0] ev, input bit ce);
    exp_t e;
    e.at = at; e.key = k; e.sw = s; e.press = p; e.rel = r; e.evt = ev; e.chk_evt = ce;
    exp_q.push_back(e);
  endtask

  // Hold the current inputs and expect a steady output every cycle.
  task automatic idle(input int n, input logic [KEY_W-1:0] k, input logic [SW_W-1:0] s);
    for (int j = 0; j < n; j++) begin
      step();
      push(cyc + 1, k, s, 3'b000, 3'b000, 3'b000, 1'b0);
    end
  endtask

  int n;
  int m;
  int guard;
  logic [6:0] bounce;

  initial begin
    reset   = 1'b1;
    key_raw = 3'b111;
    sw_raw  = 10'h000;
`ifdef IO_INPUT_COND_STICKY_EN
    evt_clr = 3'b000;
`endif
    repeat (3) step();
    mon_en = 1'b1;
    push(cyc + 1, 3'b111, 10'h000, 3'b000, 3'b000, 3'b000, 1'b0);
    step();
    reset = 1'b0;

    // 1: quiet after reset
    idle(20, 3'b111, 10'h000);

    // 2: KEY[0] press, then release
    step(); n = cyc;
    key_raw = 3'b110;
    push(n + 5, 3'b111, 10'h000, 3'b000, 3'b000, 3'b000, 1'b0);
    push(n + 6, 3'b110, 10'h000, 3'b001, 3'b000, 3'b000, 1'b0);
    push(n + 7, 3'b110, 10'h000, 3'b000, 3'b000, 3'b000, 1'b0);
    repeat (10) step();
    m = cyc;
    key_raw = 3'b111;
    push(m + 5, 3'b110, 10'h000, 3'b000, 3'b000, 3'b000, 1'b0);
    push(m + 6, 3'b111, 10'h000, 3'b000, 3'b001, 3'b000, 1'b0);
    push(m + 7, 3'b111, 10'h000, 3'b000, 3'b000, 3'b000, 1'b0);
    repeat (10) step();

    // 3: KEY[1] bounce, never low long enough
    bounce = 7'b1000100;  // bit j = level in cycle j: L L H L L L H reversed order
    for (int r = 0; r < 10; r++) begin
      for (int j = 6; j >= 0; j--) begin
        step();
        key_raw = {1'b1, bounce[j], 1'b1};
        push(cyc + 1, 3'b111, 10'h000, 3'b000, 3'b000, 3'b000, 1'b0);
      end
    end
    step();
    key_raw = 3'b111;
    idle(8, 3'b111, 10'h000);

    // 4: switches and KEY[2] on the same edge
    step(); n = cyc;
    sw_raw  = 10'h2A5;
    key_raw = 3'b011;
    push(n + 5, 3'b111, 10'h000, 3'b000, 3'b000, 3'b000, 1'b0);
    push(n + 6, 3'b011, 10'h2A5, 3'b100, 3'b000, 3'b000, 1'b0);
    push(n + 7, 3'b011, 10'h2A5, 3'b000, 3'b000, 3'b000, 1'b0);
    repeat (8) step();
    m = cyc;
    key_raw = 3'b111;
    push(m + 5, 3'b011, 10'h2A5, 3'b000, 3'b000, 3'b000, 1'b0);
    push(m + 6, 3'b111, 10'h2A5, 3'b000, 3'b100, 3'b000, 1'b0);
    repeat (8) step();

    // 5: reset in the middle of a KEY[0] debounce
    step(); n = cyc;
    key_raw = 3'b110;
    push(n + 3, 3'b111, 10'h2A5, 3'b000, 3'b000, 3'b000, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    push(n + 4, 3'b111, 10'h000, 3'b000, 3'b000, 3'b000, 1'b0);
    step();
    push(n + 5, 3'b111, 10'h000, 3'b000, 3'b000, 3'b000, 1'b0);
    step();
    reset = 1'b0;
    for (int k = 6; k <= 10; k++) push(n + k, 3'b111, 10'h000, 3'b000, 3'b000, 3'b000, 1'b0);
    push(n + 11, 3'b110, 10'h2A5, 3'b001, 3'b000, 3'b000, 1'b0);
    push(n + 12, 3'b110, 10'h2A5, 3'b000, 3'b000, 3'b000, 1'b0);
    repeat (10) step();
    m = cyc;
    key_raw = 3'b111;
    push(m + 6, 3'b111, 10'h2A5, 3'b000, 3'b001, 3'b000, 1'b0);
    repeat (8) step();

`ifdef IO_INPUT_COND_STICKY_EN
    // 6: sticky press event
    step();
    evt_clr = 3'b111;
    step();
    evt_clr = 3'b000;
    step(); n = cyc;
    key_raw = 3'b110;
    push(n + 5, 3'b111, 10'h2A5, 3'b000, 3'b000, 3'b000, 1'b1);
    push(n + 6, 3'b110, 10'h2A5, 3'b001, 3'b000, 3'b000, 1'b1);
    push(n + 7, 3'b110, 10'h2A5, 3'b000, 3'b000, 3'b001, 1'b1);
    push(n + 10, 3'b110, 10'h2A5, 3'b000, 3'b000, 3'b001, 1'b1);
    repeat (10) step();
    evt_clr = 3'b001;
    push(n + 11, 3'b110, 10'h2A5, 3'b000, 3'b000, 3'b000, 1'b1);
    step();
    evt_clr = 3'b000;
    m = cyc;
    key_raw = 3'b111;
    push(m + 6, 3'b111, 10'h2A5, 3'b000, 3'b001, 3'b000, 1'b1);
    repeat (8) step();
    step(); n = cyc;
    key_raw = 3'b110;
    push(n + 6, 3'b110, 10'h2A5, 3'b001, 3'b000, 3'b000, 1'b1);
    repeat (6) step();
    evt_clr = 3'b001;
    push(n + 7, 3'b110, 10'h2A5, 3'b000, 3'b000, 3'b001, 1'b1);
    step();
    evt_clr = 3'b000;
    push(n + 8, 3'b110, 10'h2A5, 3'b000, 3'b000, 3'b001, 1'b1);
    repeat (4) step();
`endif

    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      step();
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
